// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, branch condition codes, flag bit positions
// and the flag/branch unit state encoding.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        CC_NE = 3'b000,
        CC_EQ = 3'b001,
        CC_GT = 3'b010,
        CC_LT = 3'b011,
        CC_GE = 3'b100,
        CC_LE = 3'b101,
        CC_OV = 3'b110,
        CC_AL = 3'b111
    } ccc_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        HALTED   = 2'd2
    } fbu_state_t;

    // Arithmetic ops update all three flags; shifts/rotates/XOR update Z only.
    function automatic logic writes_vnz(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic writes_z_only(input opcode_t op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/flag_branch_unit_branch_cond.sv
// Combinational branch condition evaluation of a 3-bit condition code
// against the architectural {V,N,Z} flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] ccc_i,
    input  logic [2:0] flags_i,
    output logic       take_o
);

    logic z, n, v;

    assign z = flags_i[FLAG_Z];
    assign n = flags_i[FLAG_N];
    assign v = flags_i[FLAG_V];

    always_comb begin
        take_o = 1'b0;
        case (ccc_t'(ccc_i))
            CC_NE:   take_o = ~z;
            CC_EQ:   take_o = z;
            CC_GT:   take_o = ~z & ~n;
            CC_LT:   take_o = n;
            CC_GE:   take_o = z | (~z & ~n);
            CC_LE:   take_o = n | z;
            CC_OV:   take_o = v;
            CC_AL:   take_o = 1'b1;
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Execute-stage flag register, B/BR resolution with registered redirect/flush,
// and HLT halt state. Optional branch counters under macro BRANCH_STATS_EN.
module flag_branch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            stall,
    input  logic [3:0]      ex_opcode,
    input  logic [2:0]      alu_flags,
    input  logic [2:0]      ex_ccc,
    input  logic [PC_W-1:0] ex_pc_plus2,
    input  logic [IMM_W-1:0] ex_imm,
    input  logic [PC_W-1:0] ex_rs_val,
    output logic [2:0]      flags_q,
    output logic            br_taken,
    output logic [PC_W-1:0] br_target,
    output logic            flush,
    output logic            halt
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     br_total_cnt,
    output logic [15:0]     br_taken_cnt
`endif
);

    fbu_state_t      state_q, state_d;
    opcode_t         op;
    logic            accept;
    logic            is_branch;
    logic            cond_true;
    logic            take_branch;
    logic [2:0]      flags_d;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] target;
    logic            br_taken_q, br_taken_d;
    logic            flush_q, flush_d;
    logic            halt_q, halt_d;
    logic [PC_W-1:0] br_target_q, br_target_d;

    assign op          = opcode_t'(ex_opcode);
    assign accept      = ex_valid & ~stall & (state_q == RUN);
    assign is_branch   = (op == OP_B) | (op == OP_BR);
    assign take_branch = accept & is_branch & cond_true;

    branch_cond u_branch_cond (
        .ccc_i   (ex_ccc),
        .flags_i (flags_q),
        .take_o  (cond_true)
    );

    // Word offset: sign-extend then scale by two; the add wraps modulo 2^PC_W.
    assign offset = {{(PC_W-IMM_W-1){ex_imm[IMM_W-1]}}, ex_imm, 1'b0};
    assign target = (op == OP_B) ? (ex_pc_plus2 + offset) : ex_rs_val;

    always_comb begin
        flags_d = flags_q;
        if (accept) begin
            if (writes_vnz(op)) begin
                flags_d = alu_flags;
            end else if (writes_z_only(op)) begin
                flags_d[FLAG_Z] = alu_flags[FLAG_Z];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flags_q     <= 3'b000;
            br_taken_q  <= 1'b0;
            flush_q     <= 1'b0;
            halt_q      <= 1'b0;
            br_target_q <= '0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            br_taken_q  <= br_taken_d;
            flush_q     <= flush_d;
            halt_q      <= halt_d;
            br_target_q <= br_target_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (take_branch) begin
                    state_d = REDIRECT;
                end else if (accept && (op == OP_HLT)) begin
                    state_d = HALTED;
                end
            end
            REDIRECT: begin
                if (!stall) begin
                    state_d = RUN;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        br_taken_d  = (state_d == REDIRECT);
        flush_d     = (state_d == REDIRECT);
        halt_d      = (state_d == HALTED);
        br_target_d = take_branch ? target : br_target_q;
    end

    assign br_taken  = br_taken_q;
    assign flush     = flush_q;
    assign halt      = halt_q;
    assign br_target = br_target_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] br_total_q, br_total_d;
    logic [15:0] br_tk_q, br_tk_d;

    // accept already excludes HALTED, so the counters freeze there.
    always_comb begin
        br_total_d = br_total_q;
        br_tk_d    = br_tk_q;
        if (accept && is_branch && (br_total_q != 16'hFFFF)) begin
            br_total_d = br_total_q + 16'd1;
        end
        if (take_branch && (br_tk_q != 16'hFFFF)) begin
            br_tk_d = br_tk_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total_q <= 16'd0;
            br_tk_q    <= 16'd0;
        end else begin
            br_total_q <= br_total_d;
            br_tk_q    <= br_tk_d;
        end
    end

    assign br_total_cnt = br_total_q;
    assign br_taken_cnt = br_tk_q;
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed cases plus randomized
// traffic against a behavioural model (define BRANCH_STATS_EN for counters).
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  ex_opcode = 4'h0;
    logic [2:0]  alu_flags = 3'b000;
    logic [2:0]  ex_ccc = 3'b000;
    logic [15:0] ex_pc_plus2 = 16'h0000;
    logic [8:0]  ex_imm = 9'h000;
    logic [15:0] ex_rs_val = 16'h0000;
    logic [2:0]  flags_q;
    logic        br_taken;
    logic [15:0] br_target;
    logic        flush;
    logic        halt;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_total_cnt;
    logic [15:0] br_taken_cnt;
`endif

    flag_branch_unit #(.PC_W(16), .IMM_W(9)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .stall       (stall),
        .ex_opcode   (ex_opcode),
        .alu_flags   (alu_flags),
        .ex_ccc      (ex_ccc),
        .ex_pc_plus2 (ex_pc_plus2),
        .ex_imm      (ex_imm),
        .ex_rs_val   (ex_rs_val),
        .flags_q     (flags_q),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .flush       (flush),
        .halt        (halt)
`ifdef BRANCH_STATS_EN
        ,
        .br_total_cnt (br_total_cnt),
        .br_taken_cnt (br_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: flags as a number, plus "a redirect is showing" and
    // "the machine has stopped" booleans, and plain integer branch tallies.
    bit [2:0]  m_flags;
    bit        m_redir;
    bit        m_halt;
    bit [15:0] m_tgt;
    int        m_tot;
    int        m_tk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_true(input bit [2:0] c, input bit [2:0] f);
        bit z, n, v;
        z = f[0]; n = f[1]; v = f[2];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = 3'b000; m_redir = 0; m_halt = 0; m_tgt = 16'h0; m_tot = 0; m_tk = 0;
    endtask

    task automatic model_step();
        int off;
        if (m_halt) return;
        if (m_redir) begin
            if (!stall) m_redir = 0;
            return;
        end
        if (!ex_valid || stall) return;
        case (ex_opcode)
            4'h0, 4'h1: m_flags = alu_flags;
            4'h2, 4'h4, 4'h5, 4'h6: m_flags[0] = alu_flags[0];
            4'hC, 4'hD: begin
                m_tot = (m_tot < 65535) ? m_tot + 1 : m_tot;
                if (cond_true(ex_ccc, m_flags)) begin
                    m_tk = (m_tk < 65535) ? m_tk + 1 : m_tk;
                    m_redir = 1;
                    if (ex_opcode == 4'hC) begin
                        off = (ex_imm >= 9'd256) ? int'(ex_imm) - 512 : int'(ex_imm);
                        m_tgt = 16'((int'(ex_pc_plus2) + 2 * off) & 32'hFFFF);
                    end else begin
                        m_tgt = ex_rs_val;
                    end
                end
            end
            4'hF: m_halt = 1;
            default: ;
        endcase
    endtask

    // Drive one cycle's inputs, let the model consume them at the edge,
    // and return 1 time unit after the edge.
    task automatic cyc(input logic v, input logic st, input logic [3:0] op,
                       input logic [2:0] fl, input logic [2:0] cc,
                       input logic [15:0] pc, input logic [8:0] imm, input logic [15:0] rs);
        ex_valid = v; stall = st; ex_opcode = op; alu_flags = fl;
        ex_ccc = cc; ex_pc_plus2 = pc; ex_imm = imm; ex_rs_val = rs;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'h0, 3'b000, 3'b000, 16'h0, 9'h0, 16'h0);
    endtask

    task automatic do_reset();
        cmp_en = 1'b0;
        rst_n = 1'b0;
        ex_valid = 1'b0; stall = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("flags_q", {29'd0, flags_q}, {29'd0, m_flags});
            chk("br_taken", {31'd0, br_taken}, {31'd0, m_redir});
            chk("flush", {31'd0, flush}, {31'd0, m_redir});
            chk("halt", {31'd0, halt}, {31'd0, m_halt});
            chk("br_target", {16'd0, br_target}, {16'd0, m_tgt});
`ifdef BRANCH_STATS_EN
            chk("br_total_cnt", {16'd0, br_total_cnt}, m_tot);
            chk("br_taken_cnt", {16'd0, br_taken_cnt}, m_tk);
`endif
        end
    end

    initial begin
        logic [3:0] op;
        model_reset();
        #3;
        chk("rst flags", {29'd0, flags_q}, 32'h0);
        chk("rst br_taken", {31'd0, br_taken}, 32'h0);
        chk("rst halt", {31'd0, halt}, 32'h0);
        chk("rst flush", {31'd0, flush}, 32'h0);
        do_reset();

        // Flag updates
        cyc(1, 0, 4'h0, 3'b101, 3'b000, 16'h0, 9'h0, 16'h0);
        chk("add flags", {29'd0, flags_q}, 32'h5);
        cyc(1, 0, 4'h2, 3'b010, 3'b000, 16'h0, 9'h0, 16'h0);
        chk("xor flags", {29'd0, flags_q}, 32'h4);
        cyc(1, 0, 4'hA, 3'b111, 3'b000, 16'h0, 9'h0, 16'h0);
        chk("llb flags", {29'd0, flags_q}, 32'h4);

        // Taken B with negative offset, then squashed follower
        cyc(1, 0, 4'h1, 3'b001, 3'b000, 16'h0, 9'h0, 16'h0);
        cyc(1, 0, 4'hC, 3'b000, 3'b001, 16'h0010, 9'h1FE, 16'h0);
        chk("b taken", {31'd0, br_taken}, 32'h1);
        chk("b flush", {31'd0, flush}, 32'h1);
        chk("b target", {16'd0, br_target}, 32'h000C);
        cyc(1, 0, 4'h0, 3'b110, 3'b000, 16'h0, 9'h0, 16'h0);
        chk("squash flags", {29'd0, flags_q}, 32'h1);
        chk("redirect ends", {31'd0, br_taken}, 32'h0);

        // Not-taken and wrap-around target, BR target
        cyc(1, 0, 4'h0, 3'b000, 3'b000, 16'h0, 9'h0, 16'h0);
        cyc(1, 0, 4'hC, 3'b000, 3'b011, 16'h0040, 9'h004, 16'h0);
        chk("lt not taken", {31'd0, br_taken}, 32'h0);
        cyc(1, 0, 4'hC, 3'b000, 3'b111, 16'hFFFE, 9'h002, 16'h0);
        chk("wrap target", {16'd0, br_target}, 32'h0002);
        idle();
        cyc(1, 0, 4'hD, 3'b000, 3'b111, 16'h0, 9'h0, 16'h1234);
        chk("br target", {16'd0, br_target}, 32'h1234);
        idle();

        // Stall held in REDIRECT, then stalled ADD
        cyc(1, 0, 4'hD, 3'b000, 3'b111, 16'h0, 9'h0, 16'hBEEF);
        repeat (3) begin
            cyc(1, 1, 4'h0, 3'b111, 3'b000, 16'h0, 9'h0, 16'h0);
            chk("stall taken", {31'd0, br_taken}, 32'h1);
            chk("stall target", {16'd0, br_target}, 32'hBEEF);
        end
        idle();
        chk("stall release", {31'd0, br_taken}, 32'h0);
        repeat (3) cyc(1, 1, 4'h0, 3'b110, 3'b000, 16'h0, 9'h0, 16'h0);
        chk("stalled add", {29'd0, flags_q}, 32'h0);
        cyc(1, 0, 4'h0, 3'b110, 3'b000, 16'h0, 9'h0, 16'h0);
        chk("add after stall", {29'd0, flags_q}, 32'h6);

        // Async reset while in REDIRECT
        cyc(1, 0, 4'hC, 3'b000, 3'b111, 16'h1000, 9'h010, 16'h0);
        chk("pre-reset taken", {31'd0, br_taken}, 32'h1);
        cmp_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async br_taken", {31'd0, br_taken}, 32'h0);
        chk("async flush", {31'd0, flush}, 32'h0);
        chk("async target", {16'd0, br_target}, 32'h0);
        chk("async flags", {29'd0, flags_q}, 32'h0);
        do_reset();

        // Branch tally then HLT; halted machine ignores everything
        cyc(1, 0, 4'hC, 3'b000, 3'b111, 16'h0100, 9'h002, 16'h0);
        idle();
        cyc(1, 0, 4'hC, 3'b000, 3'b110, 16'h0100, 9'h002, 16'h0);
        cyc(1, 0, 4'hD, 3'b000, 3'b000, 16'h0, 9'h0, 16'h2222);
        idle();
        cyc(1, 0, 4'hF, 3'b000, 3'b000, 16'h0, 9'h0, 16'h0);
        chk("hlt", {31'd0, halt}, 32'h1);
        cyc(1, 0, 4'h0, 3'b111, 3'b000, 16'h0, 9'h0, 16'h0);
        chk("halted flags", {29'd0, flags_q}, 32'h0);
        cyc(1, 0, 4'hC, 3'b000, 3'b111, 16'h0, 9'h0, 16'h0);
        chk("halted no branch", {31'd0, br_taken}, 32'h0);
        chk("halted target", {16'd0, br_target}, 32'h2222);
`ifdef BRANCH_STATS_EN
        chk("stat total", {16'd0, br_total_cnt}, 32'd3);
        chk("stat taken", {16'd0, br_taken_cnt}, 32'd2);
`endif

        // Randomized traffic
        for (int seg = 0; seg < 12; seg++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && ($urandom_range(0, 9) != 0)) op = 4'hC;
                if ($urandom_range(0, 3) == 0) op = 4'hC + 4'($urandom_range(0, 1));
                cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), op,
                    3'($urandom), 3'($urandom), 16'($urandom), 9'($urandom), 16'($urandom));
            end
        end

        idle();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
Execute-stage neighbour directly downstream of the ALU in the 16-bit single-issue CPU. It consumes the ALU's 3-bit flags and the opcode, and holds the architectural flag register. It resolves B/BR against those flags and issues a registered redirect/flush to fetch. It also owns the HLT halt state.

Parameters:
PC_W, 16, width of PC, operands and branch target
IMM_W, 9, width of B-type signed word offset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  instruction in EX is valid
stall  in  1  pipeline stall; freezes all state
ex_opcode  in  4  EX opcode (0x0 ADD … 0xF HLT)
alu_flags  in  3  {V,N,Z} from ALU for the current EX instruction; Z=1 means result zero
ex_ccc  in  3  branch condition code
ex_pc_plus2  in  PC_W  PC of EX instruction + 2
ex_imm  in  IMM_W  signed word offset (B)
ex_rs_val  in  PC_W  register target (BR)
flags_q  out  3  architectural {V,N,Z}
br_taken  out  1  redirect request to fetch
br_target  out  PC_W  redirect address
flush  out  1  squash younger IF/ID instructions
halt  out  1  processor halted

Behaviour:
- Reset (async, rst_n=0): flags_q=3'b000, br_taken=0, br_target=0, flush=0, halt=0, state=RUN. This applies mid-operation, including from REDIRECT or HALTED.
- accept = ex_valid & ~stall & (state==RUN). Non-accepted instructions have no side effects.
- Flag write on accept, visible the next cycle:
  - ADD(0x0) and SUB(0x1) write V, N and Z.
  - XOR(0x2), SLL(0x4), SRA(0x5) and ROR(0x6) write Z only; V and N hold.
  - All other opcodes leave flags unchanged.
- Branch condition (combinational on flags_q; branches never write flags):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 always
- Target arithmetic:
  - B (0xC): ex_pc_plus2 + (sign_ext(ex_imm) << 1), truncated to PC_W (wraps modulo 2^16).
  - BR (0xD): ex_rs_val.
- FSM states RUN, REDIRECT, HALTED:
  - RUN: on accept of B/BR with condition true, go to REDIRECT and register br_target. On accept of HLT (0xF), go to HALTED. Otherwise stay in RUN.
  - REDIRECT: br_taken=1 and flush=1. The instruction presented in this state is squashed: no flag write, no branch, no halt. If stall=1, stay in REDIRECT with outputs held; otherwise return to RUN.
  - HALTED: halt=1; br_taken=0 and flush=0; all inputs ignored. Exit only by reset.
- Latency: taken branch accepted in cycle t gives br_taken/flush high in cycle t+1, lasting at least one cycle.
- Not-taken branch: no redirect, no bubble.
- Back-to-back: a flag-setting op at t followed by a branch at t+1 evaluates the updated flags_q, with no bypass needed.
- Stall while ex_valid=1: no state change; a stall held for N cycles produces no duplicate updates.
- br_taken, br_target, flush and halt are registered outputs.

Optional Feature:
BRANCH_STATS_EN
- Defined: adds output ports br_total_cnt[15:0] and br_taken_cnt[15:0], both reset to 0.
  - br_total_cnt increments on each accepted B/BR.
  - br_taken_cnt increments on each accepted taken branch.
  - Both saturate at 16'hFFFF and hold in HALTED.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode_t enum (16 opcodes)
  - ccc_t enum (8 codes)
  - flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_V=2
  - fbu_state_t enum {RUN, REDIRECT, HALTED}
- One sub-module, branch_cond: purely combinational (ccc, flags) -> take, instantiated once.

Test Plan:
- Reset check: hold rst_n=0, then release. flags_q=000, br_taken=0, halt=0. Assert rst_n=0 asynchronously while in REDIRECT; all outputs clear immediately.
- Flag updates: ADD with alu_flags=3'b101 gives flags_q=101 next cycle. XOR with alu_flags=3'b010 then gives flags_q=100 (Z cleared, V/N held). LLB leaves flags unchanged.
- Taken B: flags_q=001 (Z), ccc=001, pc_plus2=16'h0010, imm=9'h1FE (-2) -> next cycle br_taken=1, flush=1, br_target=16'h000C. The following valid instruction is squashed.
- Not-taken / wrap: flags_q=000, ccc=011 -> br_taken stays 0. Separately, ccc=111, pc_plus2=16'hFFFE, imm=9'h002 -> br_target=16'h0002. BR with rs_val=16'h1234, ccc=111 -> br_target=16'h1234.
- Stall: taken branch, then hold stall=1 for 3 cycles in REDIRECT -> br_taken stays high and the target is stable. Stalling an ADD for 3 cycles yields a single flag update.
- HLT: accept 0xF -> halt=1 next cycle. A subsequent ADD (alu_flags=111) and a taken B have no effect. With BRANCH_STATS_EN, 3 branches (2 taken) before HLT read total=3, taken=2.
